toy_mem_arbiter: RTL

- Shares one byte-wide synchronous data memory (256 x 8) between two word-level requesters: port 0 is the processor load/store port, port 1 is the host loader/debug port.
- Arbitrates between the ports round-robin.
- Sequences each 32-bit access as 4 byte beats, little-endian: byte at addr holds bits [7:0].
- Owns all memory enables and addresses; requesters never drive the memory directly.

---
 rtl/toy_mem_pkg.sv | 21 ++
 rtl/toy_rr_arb2.sv | 27 ++
 rtl/toy_mem_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/toy_mem_pkg.sv
// -----------------------------------------------------------------------------
// toy_mem_pkg
// Shared definitions for the two-port word-to-byte memory arbiter.
//   - state_e    : sequencer state encoding (IDLE, XFER, RWAIT, DONE)
//   - DEF_ADDR_W : default byte address width
//   - DEF_BEATS  : default bytes per word
// No ports (package).
// -----------------------------------------------------------------------------
package toy_mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_BEATS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_RWAIT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/toy_rr_arb2.sv
// -----------------------------------------------------------------------------
// toy_rr_arb2
// Combinational two-way round-robin pick.
//   req_i[1:0]     in  : request per port
//   last_served_i  in  : port granted most recently
//   valid_o        out : at least one request present
//   winner_o       out : granted port index
// On a tie the port that was not served last wins.
// -----------------------------------------------------------------------------
module toy_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_served_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) begin
      winner_o = ~last_served_i;
    end else begin
      // Single (or no) request: port 1 wins only if it is the one asking.
      winner_o = req_i[1];
    end
  end

endmodule

// File: rtl/toy_mem_arbiter.sv
// -----------------------------------------------------------------------------
// toy_mem_arbiter
// Shares one byte-wide synchronous memory between two word requesters.
// Each word access is issued as BEATS little-endian byte beats.
//   clk, reset                  : clock, synchronous active-high reset
//   mN_req/we/addr/wdata  (N=0,1): word request, held until mN_done
//   mN_done, mN_rdata           : one-cycle completion pulse and read word
//   mem_en/we/addr/wdata        : memory strobes (all registered)
//   mem_rdata                   : memory read byte, one cycle after strobe
//   busy, owner                 : sequencer not idle, currently granted port
// Optional macro TOY_MEM_ARB_ALIGN_CHECK_EN adds output err: a granted access
// with addr[1:0] != 0 completes immediately with err=1, rdata=0 and no
// memory strobes.
// -----------------------------------------------------------------------------
module toy_mem_arbiter
  import toy_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BEATS  = DEF_BEATS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDR_W-1:0]    m0_addr,
  input  logic [8*BEATS-1:0]   m0_wdata,
  output logic                 m0_done,
  output logic [8*BEATS-1:0]   m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDR_W-1:0]    m1_addr,
  input  logic [8*BEATS-1:0]   m1_wdata,
  output logic                 m1_done,
  output logic [8*BEATS-1:0]   m1_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 owner
`ifdef TOY_MEM_ARB_ALIGN_CHECK_EN
  ,
  output logic                 err
`endif
);

  localparam int WORD_W = 8 * BEATS;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_e              state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic                owner_q;
  logic                last_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   rbuf_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;
  logic [1:0]          done_q;
  logic [WORD_W-1:0]   rdata_q [2];

  logic                arb_valid;
  logic                arb_winner;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [WORD_W-1:0]   sel_wdata;
  logic [BEAT_W-1:0]   beat_d;
  logic [WORD_W-1:0]   rword_d;
  logic                misaligned_d;

  toy_rr_arb2 u_arb (
    .req_i         ({m1_req, m0_req}),
    .last_served_i (last_q),
    .valid_o       (arb_valid),
    .winner_o      (arb_winner)
  );

  always_comb begin
    sel_we    = arb_winner ? m1_we    : m0_we;
    sel_addr  = arb_winner ? m1_addr  : m0_addr;
    sel_wdata = arb_winner ? m1_wdata : m0_wdata;
  end

  assign beat_d = beat_q + 1'b1;

  // Assembled read word: the last byte arrives in RWAIT straight from memory.
  always_comb begin
    rword_d                = rbuf_q;
    rword_d[WORD_W-1 -: 8] = mem_rdata;
  end

`ifdef TOY_MEM_ARB_ALIGN_CHECK_EN
  logic err_q;
  assign misaligned_d = (sel_addr[1:0] != 2'b00);
  assign err          = err_q;
`else
  assign misaligned_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= '0;
      rdata_q[0]  <= '0;
      rdata_q[1]  <= '0;
`ifdef TOY_MEM_ARB_ALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= '0;
`ifdef TOY_MEM_ARB_ALIGN_CHECK_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            owner_q <= arb_winner;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            beat_q  <= '0;
            rbuf_q  <= '0;
            if (misaligned_d) begin
              state_q             <= ST_DONE;
              done_q[arb_winner]  <= 1'b1;
              rdata_q[arb_winner] <= '0;
`ifdef TOY_MEM_ARB_ALIGN_CHECK_EN
              err_q               <= 1'b1;
`endif
            end else begin
              // Beat 0 strobes are loaded here so they appear in the first XFER cycle.
              state_q     <= ST_XFER;
              mem_en_q    <= 1'b1;
              mem_we_q    <= sel_we;
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata[7:0];
            end
          end
        end
        ST_XFER: begin
          // The byte read by the previous beat is on mem_rdata now.
          if (!we_q && beat_q != '0) begin
            rbuf_q[8*(int'(beat_q)-1) +: 8] <= mem_rdata;
          end
          if (beat_q == LAST_BEAT) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (we_q) begin
              state_q         <= ST_DONE;
              done_q[owner_q] <= 1'b1;
            end else begin
              state_q <= ST_RWAIT;
            end
          end else begin
            beat_q      <= beat_d;
            mem_addr_q  <= addr_q + ADDR_W'(beat_d);
            mem_wdata_q <= wdata_q[8*int'(beat_d) +: 8];
          end
        end
        ST_RWAIT: begin
          state_q          <= ST_DONE;
          done_q[owner_q]  <= 1'b1;
          rdata_q[owner_q] <= rword_d;
        end
        ST_DONE: begin
          last_q  <= owner_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m0_done   = done_q[0];
  assign m1_done   = done_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign owner     = owner_q;

endmodule
